adc_packetizer: RTL
===================

# adc_packetizer

Multi-channel successor to the digitizer's capture path: samples CHANNELS parallel ADC words on an input strobe, or generates a per-channel ramp in test mode, and buffers them in an internal FIFO. It emits fixed-size AXI4-Stream packets, with `m_tlast` on every pkt_size-th beat, toward the DMA S2MM port. Control and status map onto the PS-side register block: start/test bits at 0x00, packet size at 0x08.

## Interface
Parameters:
- `DATA_W`, 16: bits per channel sample.
- `CHANNELS`, 2: parallel channels packed into one beat; channel k at bits [k*DATA_W +: DATA_W].
- `PKT_W`, 16: width of the packet-size field.
- `FIFO_DEPTH`, 16: FIFO entries, power of two, at least 4.

Ports:
- `clk`  in  1  single clock for the whole block.
- `resetn`  in  1  asynchronous active-low reset.
- `enable`  in  1  level; rising edge starts capture, falling edge requests stop.
- `test_mode`  in  1  sampled at start; 1 selects the ramp generator.
- `pkt_size`  in  PKT_W  beats per packet; sampled at start; 0 is treated as 1.
- `adc_valid`  in  1  one-cycle sample strobe.
- `adc_data`  in  CHANNELS*DATA_W  packed samples.
- `m_tdata`  out  CHANNELS*DATA_W  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tlast`  out  1  last beat of a packet.
- `busy`  out  1  high when state is not IDLE or the FIFO is not empty.
- `overflow`  out  1  sticky; a sample was dropped because the FIFO was full.
- `pkt_count`  out  32  packets completed on the output (tlast handshakes); wraps.

## Operation
- States:
  - IDLE -> RUN on an `enable` rising edge (`enable`=1, previous value 0).
  - RUN -> FLUSH when `enable`=0.
  - FLUSH -> IDLE when the current packet is complete, i.e. beat counter = 0 after a write. FLUSH goes straight to IDLE if the beat counter is already 0.
- Entry into RUN:
  - Latch `pkt_size` (0 becomes 1) and `test_mode`.
  - Clear the beat counter, ramp counter and `overflow`.
  - `pkt_count` is not cleared.
- Capture (RUN and FLUSH): on each `adc_valid`, form one beat.
  - Normal mode: `adc_data` as presented.
  - Test mode: channel k = ramp + k, modulo 2^DATA_W. The ramp increments by 1 per accepted beat.
- Write to FIFO with a tlast bit = (beat counter = latched size - 1). The beat counter wraps to 0 after the tlast beat.
- FIFO full on `adc_valid`:
  - The beat is dropped and `overflow` is set.
  - The beat counter and ramp do not advance, so every packet still has exactly the latched size.
  - Full is evaluated on the registered count; a simultaneous pop does not accept the write.
- `adc_valid` in IDLE is ignored.
- Output: standard AXI-Stream.
  - `m_tdata`/`m_tlast` hold stable while `m_tvalid`=1 and `m_tready`=0.
  - A pop happens on `m_tvalid & m_tready`.
  - `pkt_count` increments on a handshake with `m_tlast`=1.
- The FIFO keeps draining in IDLE; stopping never truncates a packet.
- A new `enable` rising edge while in FLUSH is ignored until IDLE is reached.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `busy`=0, `overflow`=0, `pkt_count`=0, state IDLE, FIFO empty.
- `enable` edge to state RUN: 1 cycle. The first `adc_valid` accepted is the one in the cycle after the edge.
- Write-to-output latency: a beat written at edge N gives `m_tvalid`=1 after edge N+1 if the FIFO was empty. This is a registered output stage.
- Throughput: one beat per cycle sustained on both sides. A simultaneous push and pop with count in 1..DEPTH-1 leaves count unchanged.
- `overflow` sets at the edge where the drop occurs.
- `pkt_count` updates at the edge of the tlast handshake.
- `busy` falls the cycle after the FIFO empties with the state in IDLE.
- `resetn` asserted mid-packet: all state is cleared immediately and asynchronously, and the partial packet is lost.

## Test plan
- Test mode, CHANNELS=2, pkt_size=4, `adc_valid` every cycle, `m_tready`=1 -> beats {0,1},{1,2},{2,3},{3,4} with tlast on the 4th, then {4,5}…; `pkt_count`=2 after 8 beats.
- Normal mode, pkt_size=0 -> every beat has tlast=1; `adc_data`=0xBEEF_1234 appears unchanged on `m_tdata`.
- Backpressure: `m_tready`=0 for 20 strobes with DEPTH=16 -> `overflow`=1, exactly 16 beats queued. After `m_tready`=1, tlast falls on every 4th delivered beat and the ramp is gap-free.
- `enable` dropped after beat 2 of a 4-beat packet -> 2 more strobes are accepted, the packet closes with tlast, and the state reaches IDLE. Further strobes produce no beats, and `busy` falls after the drain.
- Random `m_tready` with held tvalid -> `m_tdata`/`m_tlast` are stable while stalled, and no beat is lost or duplicated (scoreboard).
- `resetn` pulsed mid-packet -> all outputs return to their reset values within the same cycle; a restart yields ramp 0 and a full-size first packet.

Source files
------------

// File: rtl/adc_packetizer.sv
// adc_packetizer
//
// Captures CHANNELS parallel ADC samples on each adc_valid strobe (or, in
// test mode, a per-channel ramp), queues them in an internal FIFO and sends
// them out as fixed-size AXI4-Stream packets. m_tlast marks every
// pkt_size-th beat, so each packet carries exactly the latched size.
//
// Ports:
//   clk        - single clock for the whole block
//   resetn     - asynchronous active-low reset
//   enable     - level; rising edge starts capture, falling edge requests stop
//   test_mode  - sampled at start; 1 selects the ramp generator
//   pkt_size   - beats per packet, sampled at start (0 is treated as 1)
//   adc_valid  - one-cycle sample strobe
//   adc_data   - packed samples, channel k at [k*DATA_W +: DATA_W]
//   m_tdata    - stream data
//   m_tvalid   - stream valid
//   m_tready   - stream ready
//   m_tlast    - last beat of a packet
//   busy       - capture active or FIFO still holding data
//   overflow   - sticky; a sample was dropped because the FIFO was full
//   pkt_count  - packets completed on the output (tlast handshakes), wraps

module adc_packetizer #(
    parameter int DATA_W     = 16,
    parameter int CHANNELS   = 2,
    parameter int PKT_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic                       test_mode,
    input  logic [PKT_W-1:0]           pkt_size,
    input  logic                       adc_valid,
    input  logic [CHANNELS*DATA_W-1:0] adc_data,
    output logic [CHANNELS*DATA_W-1:0] m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic                       busy,
    output logic                       overflow,
    output logic [31:0]                pkt_count
);

    localparam int BEAT_W = CHANNELS * DATA_W;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    // Capture-side state
    state_t             state_q, state_d;
    logic               enable_prev_q, enable_prev_d;
    logic [PKT_W-1:0]   size_q, size_d;
    logic               test_q, test_d;
    logic [PKT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]  ramp_q, ramp_d;
    logic               overflow_q, overflow_d;

    // FIFO state; each entry is {tlast, data}
    logic [BEAT_W:0]    mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Registered output stage and status
    logic               out_valid_q, out_valid_d;
    logic [BEAT_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [31:0]        pkt_count_q, pkt_count_d;
    logic               busy_q, busy_d;

    // Combinational helpers
    logic               start;
    logic               capture;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               beat_last;
    logic [BEAT_W-1:0]  test_beat;
    logic [BEAT_W:0]    wr_entry;
    logic [CNT_W-1:0]   remaining;

    // Ramp beat: channel k carries ramp + k, wrapping at 2^DATA_W.
    always_comb begin
        test_beat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            test_beat[k*DATA_W +: DATA_W] = ramp_q + DATA_W'(k);
        end
    end

    // Capture qualification. In FLUSH with the beat counter at 0 the packet
    // is already closed, so no new packet may be opened.
    always_comb begin
        start     = (state_q == ST_IDLE) && enable && !enable_prev_q;
        capture   = adc_valid &&
                    ((state_q == ST_RUN) ||
                     ((state_q == ST_FLUSH) && (beat_cnt_q != '0)));
        // Full uses the registered count only; a same-cycle pop does not
        // make room for the write.
        fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
        push      = capture && !fifo_full;
        beat_last = (beat_cnt_q == size_q - PKT_W'(1));
        wr_entry  = {beat_last, (test_q ? test_beat : adc_data)};
        pop       = out_valid_q && m_tready;
    end

    // Control FSM next state, start-of-run latching and beat/ramp counters.
    always_comb begin
        state_d       = state_q;
        enable_prev_d = enable;
        size_d        = size_q;
        test_d        = test_q;
        beat_cnt_d    = beat_cnt_q;
        ramp_d        = ramp_q;
        overflow_d    = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    size_d     = (pkt_size == '0) ? PKT_W'(1) : pkt_size;
                    test_d     = test_mode;
                    beat_cnt_d = '0;
                    ramp_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (beat_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (push && beat_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A dropped beat advances neither counter, keeping packet size exact
        // and the ramp gap-free.
        if (capture) begin
            if (fifo_full) begin
                overflow_d = 1'b1;
            end else begin
                beat_cnt_d = beat_last ? '0 : beat_cnt_q + PKT_W'(1);
                ramp_d     = ramp_q + DATA_W'(1);
            end
        end
    end

    // FIFO pointers, occupancy and the registered output stage. The count
    // includes the entry presented on the output; it is only freed on the
    // handshake. The output register reloads from the registered memory, so
    // a beat written into an empty FIFO appears one cycle after its write.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d    = rd_ptr_q + ADDR_W'(pop);
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        remaining   = count_q - CNT_W'(pop);
        out_valid_d = (remaining != '0);
        {out_last_d, out_data_d} = mem_q[rd_ptr_d];
        pkt_count_d = pkt_count_q + 32'(pop && out_last_q);
        busy_d      = (state_q != ST_IDLE) || (count_q != '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            enable_prev_q <= 1'b0;
            size_q        <= PKT_W'(1);
            test_q        <= 1'b0;
            beat_cnt_q    <= '0;
            ramp_q        <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            pkt_count_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            enable_prev_q <= enable_prev_d;
            size_q        <= size_d;
            test_q        <= test_d;
            beat_cnt_q    <= beat_cnt_d;
            ramp_q        <= ramp_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            pkt_count_q   <= pkt_count_d;
            busy_q        <= busy_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign m_tdata   = out_data_q;
    assign m_tvalid  = out_valid_q;
    assign m_tlast   = out_last_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign pkt_count = pkt_count_q;

endmodule
